// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read slave between two masters; the grant is held from AR through RLast.
// Arbitration costs one idle cycle, then AR/R pass through combinationally; only the granted master sees ready/valid.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              rst,
  input  logic [ID_W-1:0]   M0_ARID,
  input  logic [ADDR_W-1:0] M0_ARAddr,
  input  logic [LEN_W-1:0]  M0_ARLen,
  input  logic [2:0]        M0_ARSize,
  input  logic [1:0]        M0_ARBurst,
  input  logic              M0_ARValid,
  output logic              M0_ARReady,
  output logic [ID_W-1:0]   M0_RID,
  output logic [DATA_W-1:0] M0_RData,
  output logic [1:0]        M0_RResp,
  output logic              M0_RLast,
  output logic              M0_RValid,
  input  logic              M0_RReady,
  input  logic [ID_W-1:0]   M1_ARID,
  input  logic [ADDR_W-1:0] M1_ARAddr,
  input  logic [LEN_W-1:0]  M1_ARLen,
  input  logic [2:0]        M1_ARSize,
  input  logic [1:0]        M1_ARBurst,
  input  logic              M1_ARValid,
  output logic              M1_ARReady,
  output logic [ID_W-1:0]   M1_RID,
  output logic [DATA_W-1:0] M1_RData,
  output logic [1:0]        M1_RResp,
  output logic              M1_RLast,
  output logic              M1_RValid,
  input  logic              M1_RReady,
  output logic [ID_W+3:0]   S_ARID,
  output logic [ADDR_W-1:0] S_ARAddr,
  output logic [LEN_W-1:0]  S_ARLen,
  output logic [2:0]        S_ARSize,
  output logic [1:0]        S_ARBurst,
  output logic              S_ARValid,
  input  logic              S_ARReady,
  input  logic [ID_W+3:0]   S_RID,
  input  logic [DATA_W-1:0] S_RData,
  input  logic [1:0]        S_RResp,
  input  logic              S_RLast,
  input  logic              S_RValid,
  output logic              S_RReady
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic       gnt;
  logic       last;
  logic       in_addr;
  logic       in_data;
  logic       ar_hs;
  logic       r_done;
  logic       unused_rid_hi;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign ar_hs   = S_ARValid && S_ARReady;
  assign r_done  = S_RValid && S_RReady && S_RLast;

  always_ff @(posedge ACLK) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (M0_ARValid || M1_ARValid) begin
            // On a tie the master that did not finish most recently wins.
            gnt   <= (M0_ARValid && M1_ARValid) ? !last : M1_ARValid;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) state <= DATA;
        end
        DATA: begin
          if (r_done) begin
            last  <= gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign S_ARID    = gnt ? {4'd2, M1_ARID} : {4'd1, M0_ARID};
  assign S_ARAddr  = gnt ? M1_ARAddr  : M0_ARAddr;
  assign S_ARLen   = gnt ? M1_ARLen   : M0_ARLen;
  assign S_ARSize  = gnt ? M1_ARSize  : M0_ARSize;
  assign S_ARBurst = gnt ? M1_ARBurst : M0_ARBurst;
  assign S_ARValid = in_addr && (gnt ? M1_ARValid : M0_ARValid);
  assign M0_ARReady = in_addr && !gnt && S_ARReady;
  assign M1_ARReady = in_addr &&  gnt && S_ARReady;

  // Return data is routed purely by the held grant; the slave's ID tag is not consulted.
  assign S_RReady  = in_data && (gnt ? M1_RReady : M0_RReady);
  assign M0_RValid = in_data && !gnt && S_RValid;
  assign M1_RValid = in_data &&  gnt && S_RValid;

  assign M0_RID   = S_RID[ID_W-1:0];
  assign M1_RID   = S_RID[ID_W-1:0];
  assign M0_RData = S_RData;
  assign M1_RData = S_RData;
  assign M0_RResp = S_RResp;
  assign M1_RResp = S_RResp;
  assign M0_RLast = S_RLast;
  assign M1_RLast = S_RLast;

  assign unused_rid_hi = ^S_RID[ID_W+3:ID_W];
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: queue-driven masters and slave, a transaction-level arbitration model
// compared every cycle, plus directed literal checks on latency, grant order, backpressure and reset.
module tb_axi_read_arbiter;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  typedef struct packed {
    logic [ID_W+3:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } sreq_t;

  typedef struct {
    int              cyc;
    logic [ID_W+3:0] id;
  } sar_ev_t;

  logic ACLK = 1'b0;
  logic rst  = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [1:0][ID_W-1:0]   arid;
  logic [1:0][ADDR_W-1:0] araddr;
  logic [1:0][LEN_W-1:0]  arlen;
  logic [1:0][2:0]        arsize;
  logic [1:0][1:0]        arburst;
  logic [1:0]             arvalid, arready, rvalid, rready, rlast;
  logic [1:0][ID_W-1:0]   rid;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0][1:0]        rresp;

  logic [ID_W+3:0]   s_arid, s_rid;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst, s_rresp;
  logic              s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;

  axi_read_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .rst(rst),
    .M0_ARID(arid[0]), .M0_ARAddr(araddr[0]), .M0_ARLen(arlen[0]), .M0_ARSize(arsize[0]),
    .M0_ARBurst(arburst[0]), .M0_ARValid(arvalid[0]), .M0_ARReady(arready[0]),
    .M0_RID(rid[0]), .M0_RData(rdata[0]), .M0_RResp(rresp[0]), .M0_RLast(rlast[0]),
    .M0_RValid(rvalid[0]), .M0_RReady(rready[0]),
    .M1_ARID(arid[1]), .M1_ARAddr(araddr[1]), .M1_ARLen(arlen[1]), .M1_ARSize(arsize[1]),
    .M1_ARBurst(arburst[1]), .M1_ARValid(arvalid[1]), .M1_ARReady(arready[1]),
    .M1_RID(rid[1]), .M1_RData(rdata[1]), .M1_RResp(rresp[1]), .M1_RLast(rlast[1]),
    .M1_RValid(rvalid[1]), .M1_RReady(rready[1]),
    .S_ARID(s_arid), .S_ARAddr(s_araddr), .S_ARLen(s_arlen), .S_ARSize(s_arsize),
    .S_ARBurst(s_arburst), .S_ARValid(s_arvalid), .S_ARReady(s_arready),
    .S_RID(s_rid), .S_RData(s_rdata), .S_RResp(s_rresp), .S_RLast(s_rlast),
    .S_RValid(s_rvalid), .S_RReady(s_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: which master owns the slave (-1 = none), whether its address went out, who finished last.
  int owner = -1;
  bit adone = 1'b0;
  int prev  = 1;

  req_t  rq0[$], rq1[$];
  sreq_t sq[$];
  int    beat = 0;
  int    ar_block = 0;
  int    rr_block[2] = '{0, 0};

  logic [1:0] hs_ar = '0;
  bit         hs_sar = 1'b0, hs_sr = 1'b0;
  sreq_t      cap;

  logic [DATA_W-1:0] rx0[$], rx1[$];
  sar_ev_t           sar_log[$];
  int                arv_rise[2] = '{0, 0};
  int                rlast_cyc[2] = '{0, 0};
  int                ar_hs_cyc = 0, stall_cnt = 0, rr_low_cnt = 0, m1_rv_cnt = 0;
  logic [ID_W-1:0]   last_rid0 = '0;
  logic [1:0]        arv_prev = '0;
  bit                sarv_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge ACLK) begin
    int o;
    bit aph, dph;
    cyc++;
    o   = (owner < 0) ? 0 : owner;
    aph = (owner >= 0) && !adone;
    dph = (owner >= 0) && adone;
    chk("S_ARValid", s_arvalid, aph && arvalid[o]);
    chk("S_RReady", s_rready, dph && rready[o]);
    for (int m = 0; m < 2; m++) begin
      chk("ARReady", arready[m], aph && (o == m) && s_arready);
      chk("RValid", rvalid[m], dph && (o == m) && s_rvalid);
      chk("RData", rdata[m], s_rdata);
      chk("RResp", rresp[m], s_rresp);
      chk("RLast", rlast[m], s_rlast);
      if (dph && (o == m) && s_rvalid) chk("RID", rid[m], s_rid[ID_W-1:0]);
    end
    if (aph && arvalid[o]) begin
      chk("S_ARID", s_arid, {4'(o + 1), arid[o]});
      chk("S_ARAddr", s_araddr, araddr[o]);
      chk("S_ARLen", s_arlen, arlen[o]);
      chk("S_ARSize", s_arsize, arsize[o]);
      chk("S_ARBurst", s_arburst, arburst[o]);
    end

    hs_ar  = arvalid & arready;
    hs_sar = s_arvalid && s_arready;
    hs_sr  = s_rvalid && s_rready;
    if (hs_sar) cap = '{s_arid, s_araddr, s_arlen};
    for (int m = 0; m < 2; m++)
      if (arvalid[m] && !arv_prev[m]) arv_rise[m] = cyc;
    if (rvalid[0] && rready[0]) begin
      rx0.push_back(rdata[0]);
      last_rid0 = rid[0];
      if (rlast[0]) rlast_cyc[0] = cyc;
    end
    if (rvalid[1] && rready[1]) begin
      rx1.push_back(rdata[1]);
      if (rlast[1]) rlast_cyc[1] = cyc;
    end
    if (s_arvalid && !sarv_prev) sar_log.push_back('{cyc, s_arid});
    if (hs_ar[0]) ar_hs_cyc = cyc;
    if (s_arvalid && !s_arready) stall_cnt++;
    if (rvalid[1] && !s_rready) rr_low_cnt++;
    if (rvalid[1]) m1_rv_cnt++;
    arv_prev  = arvalid;
    sarv_prev = s_arvalid;

    if (rst) begin
      owner = -1;
      adone = 1'b0;
      prev  = 1;
    end else if (owner < 0) begin
      if (arvalid[0] && arvalid[1]) owner = 1 - prev;
      else if (arvalid[0])          owner = 0;
      else if (arvalid[1])          owner = 1;
      adone = 1'b0;
    end else if (!adone) begin
      if (arvalid[owner] && s_arready) adone = 1'b1;
    end else if (s_rvalid && rready[owner] && s_rlast) begin
      prev  = owner;
      owner = -1;
    end
  end

  // Masters and slave: apply the handshakes sampled at the last negedge, then drive the next cycle.
  initial begin
    arvalid = '0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0;
    s_rresp = '0; s_rlast = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      if (rst) begin
        rq0.delete(); rq1.delete(); sq.delete();
        beat = 0; ar_block = 0; rr_block = '{0, 0};
      end else begin
        if (hs_ar[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (hs_ar[1] && rq1.size() > 0) void'(rq1.pop_front());
        if (hs_sar) sq.push_back(cap);
        if (hs_sr && sq.size() > 0) begin
          if (beat == int'(sq[0].len)) begin
            void'(sq.pop_front());
            beat = 0;
          end else beat++;
        end
      end
      arvalid[0] = rq0.size() > 0;
      if (rq0.size() > 0) begin arid[0] = rq0[0].id; araddr[0] = rq0[0].addr; arlen[0] = rq0[0].len; end
      arvalid[1] = rq1.size() > 0;
      if (rq1.size() > 0) begin arid[1] = rq1[0].id; araddr[1] = rq1[0].addr; arlen[1] = rq1[0].len; end
      arsize  = {3'd2, 3'd1};
      arburst = {2'd1, 2'd2};
      s_arready = (ar_block == 0);
      if (ar_block > 0) ar_block--;
      for (int m = 0; m < 2; m++) begin
        rready[m] = (rr_block[m] == 0);
        if (rr_block[m] > 0) rr_block[m]--;
      end
      s_rvalid = sq.size() > 0;
      if (sq.size() > 0) begin
        s_rid   = sq[0].id;
        s_rdata = sq[0].addr + 32'(beat);
        s_rlast = (beat == int'(sq[0].len));
        s_rresp = 2'(beat);
      end else s_rlast = 1'b0;
    end
  end

  task automatic tick();
    @(posedge ACLK); #2;
  endtask

  task automatic push(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                      input logic [LEN_W-1:0] l);
    req_t r;
    r = '{id, a, l};
    if (m == 0) rq0.push_back(r);
    else        rq1.push_back(r);
  endtask

  task automatic clear_logs();
    sar_log.delete(); rx0.delete(); rx1.delete();
    stall_cnt = 0; rr_low_cnt = 0; m1_rv_cnt = 0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!(rq0.size() == 0 && rq1.size() == 0 && sq.size() == 0 && owner < 0) && n < 300);
    chk(name, (n < 300), 1);
    tick();
  endtask

  task automatic wait_rx(input int m, input int k, input string name);
    int n;
    n = 0;
    while (((m == 0) ? rx0.size() : rx1.size()) < k && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk(name, (n < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single M0 burst: tag, one-cycle arbitration bubble, four beats, M1 untouched.
    clear_logs();
    push(0, 4'h5, 32'h100, 4'd3);
    wait_quiet("t1_done");
    chk("t1_nar", sar_log.size(), 1);
    if (sar_log.size() > 0) begin
      chk("t1_sarid", sar_log[0].id, 8'h15);
      chk("t1_latency", sar_log[0].cyc - arv_rise[0], 1);
    end
    chk("t1_beats", rx0.size(), 4);
    for (int i = 0; i < 4; i++) if (i < rx0.size()) chk("t1_data", rx0[i], 32'h100 + i);
    chk("t1_rid", last_rid0, 4'h5);
    chk("t1_m1_rvalid", m1_rv_cnt, 0);

    // Simultaneous requests after reset: M0 first, M1 address two cycles after M0's RLast.
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    clear_logs();
    push(0, 4'h3, 32'h200, 4'd1);
    push(1, 4'hA, 32'h300, 4'd2);
    wait_quiet("t2_done");
    chk("t2_nar", sar_log.size(), 2);
    if (sar_log.size() > 1) begin
      chk("t2_first", sar_log[0].id, 8'h13);
      chk("t2_second", sar_log[1].id, 8'h2A);
      chk("t2_gap", sar_log[1].cyc - rlast_cyc[0], 2);
    end
    chk("t2_m0_beats", rx0.size(), 2);
    chk("t2_m1_beats", rx1.size(), 3);

    // Six back-to-back contended bursts alternate starting with M0.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      push(0, 4'(i), 32'h1000 + 32'(i * 16), 4'd1);
      push(1, 4'(8 + i), 32'h2000 + 32'(i * 16), 4'd0);
    end
    wait_quiet("t3_done");
    chk("t3_nar", sar_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 0) ? {4'd1, 4'(i / 2)} : {4'd2, 4'(8 + i / 2)};
      if (i < sar_log.size()) chk("t3_order", sar_log[i].id, e);
    end

    // M1 read backpressure for three cycles mid-burst.
    clear_logs();
    push(1, 4'h7, 32'h400, 4'd3);
    wait_rx(1, 1, "t4_first_beat");
    tick();
    rr_block[1] = 3;
    wait_quiet("t4_done");
    chk("t4_stall_cycles", rr_low_cnt, 3);
    chk("t4_beats", rx1.size(), 4);
    for (int i = 0; i < 4; i++) if (i < rx1.size()) chk("t4_data", rx1[i], 32'h400 + i);

    // Slave address stall of five cycles while granted.
    clear_logs();
    ar_block = 6;
    push(0, 4'h1, 32'h3000, 4'd0);
    wait_quiet("t5_done");
    chk("t5_stall_cycles", stall_cnt, 5);
    chk("t5_arready_cycle", ar_hs_cyc - arv_rise[0], 6);
    chk("t5_beats", rx0.size(), 1);

    // Reset during beat 2; afterwards M0 must win the tie again.
    clear_logs();
    push(0, 4'h2, 32'h500, 4'd3);
    wait_rx(0, 2, "t6_two_beats");
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge ACLK);
    chk("t6_outputs_zero", {s_arvalid, s_rready, arready, rvalid}, 0);
    tick();
    clear_logs();
    push(0, 4'h4, 32'h600, 4'd0);
    push(1, 4'h6, 32'h700, 4'd0);
    wait_quiet("t6_done");
    chk("t6_nar", sar_log.size(), 2);
    if (sar_log.size() > 0) chk("t6_first_after_reset", sar_log[0].id, 8'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master, one-slave arbiter for the AXI read path (AR + R channels) of a memory slave wrapper. It shares one slave read port between master 0 (instruction fetch) and master 1 (data access). Arbitration is round-robin, and a grant is held for the whole burst. Masters never see each other's traffic, and the slave sees one outstanding read at a time, tagged with an extended ID.

## Interface
Parameters:
- ID_W, 4, master-side ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, burst length width

Ports (m = 0, 1):
- ACLK  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- Mm_ARID / Mm_ARAddr / Mm_ARLen  in  ID_W / ADDR_W / LEN_W  master m read address
- Mm_ARSize  in  3  master m burst size
- Mm_ARBurst  in  2  master m burst type
- Mm_ARValid  in  1  master m address valid
- Mm_ARReady  out  1  master m address ready
- Mm_RID  out  ID_W  read ID returned to master m
- Mm_RData  out  DATA_W  read data returned to master m
- Mm_RResp  out  2  read response to master m
- Mm_RLast  out  1  last beat to master m
- Mm_RValid  out  1  read data valid to master m
- Mm_RReady  in  1  master m ready for read data
- S_ARID  out  ID_W+4  extended ID: {4'd1, M0_ARID} or {4'd2, M1_ARID}
- S_ARAddr / S_ARLen / S_ARSize / S_ARBurst  out  ADDR_W / LEN_W / 3 / 2  forwarded address fields
- S_ARValid  out  1  address valid to slave
- S_ARReady  in  1  slave address ready
- S_RID  in  ID_W+4  slave read ID
- S_RData  in  DATA_W  slave read data
- S_RResp  in  2  slave read response
- S_RLast  in  1  slave last beat
- S_RValid  in  1  slave read data valid
- S_RReady  out  1  ready to slave

## Operation
- FSM states:
  - IDLE
  - ADDR: grant held, AR forwarded
  - DATA: grant held, R forwarded
- `gnt` (1 bit) is the granted master. `last` (1 bit) is the master most recently completed.
- IDLE:
  - If neither Mm_ARValid is high, stay in IDLE.
  - If only one is high, grant it.
  - If both are high, grant `!last`.
  - When a grant is made, register `gnt` and go to ADDR.
- ADDR:
  - S_AR* = granted master's AR fields; S_ARID upper nibble per the Interface.
  - S_ARValid = Mgnt_ARValid. Mgnt_ARReady = S_ARReady.
  - On S_ARValid && S_ARReady, go to DATA.
- DATA:
  - Mgnt_RValid = S_RValid. S_RReady = Mgnt_RReady.
  - Mgnt_RID = S_RID[ID_W-1:0].
  - On S_RValid && S_RReady && S_RLast: `last <= gnt`, go to IDLE.
- Both masters always receive S_RData, S_RResp and S_RLast. Only valid/ready are gated.
- The non-granted master sees ARReady = 0 and RValid = 0 in every state.
- In IDLE, all ARReady and RValid are 0, S_ARValid = 0 and S_RReady = 0.
- S_RID upper bits are not checked. R traffic is routed by `gnt` only.
- Masters hold ARValid and fields stable until the handshake (AXI rule). A request dropped in ADDR leaves the FSM waiting in ADDR.

## Timing
- Reset: state = IDLE, `gnt` = 0, `last` = 1 (M0 wins the first tie). All valid/ready outputs are 0.
- Reset asserted in any state takes effect at the next edge, and outputs return to reset values. Any in-flight burst is abandoned; the slave is reset alongside.
- Arbitration latency: ARValid seen in IDLE at cycle t gives S_ARValid = 1 at cycle t+1 (one bubble).
- AR and R paths in ADDR/DATA are combinational pass-through; they add zero cycles.
- After the RLast handshake at cycle t, the FSM is in IDLE at t+1 and the next S_ARValid is at t+2 earliest.
- Requests that arrive while another burst is in progress wait. Their ARReady stays 0 until they are granted.
- A new ARValid arriving in the same cycle as RLast is evaluated in the following IDLE cycle.

## Test plan
- Single M0 read, ARLen = 3, ID = 4'h5: S_ARID = 8'h15, S_ARValid asserts 1 cycle after M0_ARValid. 4 beats reach M0 with M0_RID = 4'h5, M1_RValid stays 0 throughout.
- Both masters request at the same cycle right after reset: M0 is served first. M1 follows, with S_ARID = {4'd2, M1_ARID} appearing 2 cycles after M0's RLast handshake.
- Continuous requests from both masters for 6 bursts: grants alternate M0, M1, M0, …, with no starvation.
- Backpressure: M1_RReady low for 3 cycles mid-burst: S_RReady is low for the same 3 cycles, and no beat is lost or duplicated.
- S_ARReady held low for 5 cycles in ADDR: the FSM stays in ADDR, fields stay stable, and M0_ARReady rises in the same cycle as S_ARReady.
- rst asserted during beat 2 of a 4-beat burst: next cycle, state = IDLE, every valid/ready = 0, and `last` = 1.
